apb_reg_slave: RTL

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_slave_if.sv | 26 ++
 rtl/apb_reg_slave.sv | 122 ++++++++++++
 2 files changed

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between a master and apb_reg_slave.
interface apb_reg_slave_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
);
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [addrWidth-1:0]   paddr;
    logic [dataWidth-1:0]   pwdata;
    logic [dataWidth/8-1:0] pstrb;
    logic [2:0]             pprot;
    logic [dataWidth-1:0]   prdata;
    logic                   pready;
    logic                   pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register slave: NUM_REGS word registers, register 0 is a read-only ID.
// Build macro APB_SLV_STRB_EN enables byte-lane write strobes (default: full-word writes).
module apb_reg_slave #(
    parameter int                   addrWidth   = 32,
    parameter int                   dataWidth   = 32,
    parameter int                   NUM_REGS    = 8,
    parameter int                   WAIT_CYCLES = 2,
    parameter logic [dataWidth-1:0] ID_VALUE    = 32'hA5B1_0001
) (
    input  logic           clk,
    input  logic           rst,
    apb_reg_slave_if.slave bus
);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int STRB_W = dataWidth / 8;
    localparam logic [addrWidth-3:0] REG_LIMIT = (addrWidth-2)'(NUM_REGS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                              state, stateNext;
    logic [3:0]                          waitCnt, waitCntNext;
    logic                                preadyNext, pslverrNext;
    logic [dataWidth-1:0]                prdataNext;
    logic                                wrEn;
    logic [NUM_REGS-1:0][dataWidth-1:0]  regFile;
    logic [addrWidth-3:0]                idx;
    logic [IDX_W-1:0]                    idxLo;
    logic                                accErr;
    logic [dataWidth-1:0]                rdVal;
    logic [dataWidth-1:0]                accData;
    logic                                unusedBits;

    function automatic logic addrError(input logic [addrWidth-1:0] addr, input logic isWrite);
        logic [addrWidth-3:0] wordIdx;
        wordIdx = addr[addrWidth-1:2];
        return (wordIdx >= REG_LIMIT) || (addr[1:0] != 2'b00) || (isWrite && (wordIdx == '0));
    endfunction

    assign idx        = bus.paddr[addrWidth-1:2];
    assign idxLo      = idx[IDX_W-1:0];
    assign accErr     = addrError(bus.paddr, bus.pwrite);
    assign rdVal      = (idx == '0) ? ID_VALUE : regFile[idxLo];
    assign accData    = (!bus.pwrite && !accErr) ? rdVal : '0;
    assign unusedBits = ^{bus.pprot, bus.pstrb};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            waitCnt     <= '0;
            bus.pready  <= 1'b0;
            bus.pslverr <= 1'b0;
            bus.prdata  <= '0;
        end else begin
            state       <= stateNext;
            waitCnt     <= waitCntNext;
            bus.pready  <= preadyNext;
            bus.pslverr <= pslverrNext;
            bus.prdata  <= prdataNext;
        end
    end

    // Response outputs are computed one cycle early so pready/pslverr/prdata leave flops.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        preadyNext  = 1'b0;
        pslverrNext = 1'b0;
        prdataNext  = '0;
        wrEn        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.psel && !bus.penable) begin
                    stateNext   = ACCESS;
                    waitCntNext = WAIT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        preadyNext  = 1'b1;
                        pslverrNext = accErr;
                        prdataNext  = accData;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            ACCESS: begin
                if (!bus.psel) begin
                    stateNext   = IDLE;
                    waitCntNext = '0;
                end else if (bus.pready) begin
                    stateNext   = bus.penable ? DONE : IDLE;
                    waitCntNext = '0;
                    wrEn        = bus.penable && bus.pwrite && !accErr;
                end else begin
                    waitCntNext = (waitCnt == '0) ? '0 : waitCnt - 4'd1;
                    if (waitCnt <= 4'd1) begin
                        preadyNext  = 1'b1;
                        pslverrNext = accErr;
                        prdataNext  = accData;
                    end
                end
            end
            default: begin
                stateNext   = IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regFile <= '0;
        end else if (wrEn) begin
`ifdef APB_SLV_STRB_EN
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.pstrb[b]) regFile[idxLo][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
            end
`else
            regFile[idxLo] <= bus.pwdata;
`endif
        end
    end
endmodule
